complex_nco: RTL
================

// Module: complex_nco
// PURPOSE
// - Numerically controlled oscillator that sources the complex phasor stream e^(j*phi[n]) on an AXI-Stream master port.
// - Output packing is bit-identical to the complex multiplier operand ports: {im, re}, each half sign-padded when BYTE_ALIGNED.
// - Feeds the multiplier b port directly to form a digital mixer or frequency shifter.
// PARAMETERS
// - OUTPUT_WIDTH    16  bits per component; multiple of 2, range 8..24
// - PHASE_WIDTH     32  phase accumulator width
// - LUT_ADDR_WIDTH  10  quarter-wave table address bits (N = 2^LUT_ADDR_WIDTH); PHASE_WIDTH >= LUT_ADDR_WIDTH+2
// - BYTE_ALIGNED    1   1: EFF_PORT_WIDTH = ((2*OUTPUT_WIDTH+15)/16)*16; 0: EFF_PORT_WIDTH = 2*OUTPUT_WIDTH
// PORTS
// - aclk                 in   1               clock
// - aresetn              in   1               asynchronous active-low reset
// - enable               in   1               1 = generate samples
// - sync_clear           in   1               1-cycle pulse: load accumulator with phase_offset
// - phase_inc            in   PHASE_WIDTH     frequency word, unsigned modulo 2^PHASE_WIDTH
// - phase_offset         in   PHASE_WIDTH     load value used by sync_clear
// - m_axis_dout_tdata    out  EFF_PORT_WIDTH  re at [OUTPUT_WIDTH-1:0]; im at [EFF_PORT_WIDTH/2+OUTPUT_WIDTH-1 : EFF_PORT_WIDTH/2]
// - m_axis_dout_tvalid   out  1               sample valid
// - m_axis_dout_tready   in   1               downstream ready
// BEHAVIOUR
// - Reset: accumulator = 0, all pipeline valids = 0, m_axis_dout_tvalid = 0, m_axis_dout_tdata = 0.
// - advance = !(m_axis_dout_tvalid && !m_axis_dout_tready). When advance = 0, every pipeline register freezes, including the accumulator.
// - AXI rule: once tvalid = 1, tdata and tvalid remain stable until tready = 1.
// - Accumulator update (when advance = 1):
//   - sync_clear = 1: acc <= phase_offset. sync_clear takes priority over enable.
//   - else enable = 1: acc <= acc + phase_inc (wraps modulo 2^PHASE_WIDTH).
//   - A sync_clear arriving while stalled is held pending and applied on the next advance.
// - phase_inc is sampled at every accumulator update; a changed value takes effect on the next sample.
// - Pipeline (4 stages, all gated by advance):
//   - S1: phase register p = acc (value before the add); valid1 = enable.
//   - S2: decode q = p[PW-1:PW-2], a = p[PW-3 -: LUT_ADDR_WIDTH]; register q, a, ~a.
//   - S3: two table reads, T[a] and T[~a].
//   - S4: sign and select:
//     - sin: q0 +T[a], q1 +T[~a], q2 -T[a], q3 -T[~a]
//     - cos: q0 +T[~a], q1 -T[a], q2 -T[~a], q3 +T[a]
//     - re = cos, im = sin
// - Table: T[k] = round(A*sin(pi/2*(k+0.5)/N)), A = 2^(OUTPUT_WIDTH-1)-1.
//   - The half-sample offset makes the ~a mirror exact, and 0 <= T <= A, so negation never overflows.
//   - Phase bits below the table index are truncated; there is no dither.
// - Latency: enable rising with an empty pipeline and tready = 1 -> first tvalid on the 4th rising edge; afterwards one sample per cycle.
// - enable low: no new samples enter; samples already in flight drain to the output normally.
// - Padding bits of each half equal the sign of that half's component.
// - aresetn asserted mid-stream: outputs clear immediately (asynchronously); the first sample after release is phase 0 (or phase_offset if sync_clear).
// STRUCTURE
// - Shared include complex_pkg.vh holds the EFF_PORT_WIDTH formula and pack/unpack macros; the complex multiplier uses the same file.
// - Sub-module complex_nco_lut: dual-read quarter-wave ROM with 1-cycle registered read and clock enable.
//   - Contents are generated in an initial block with $sin and use the same rounding as the bench model.
// - Top level holds the accumulator, the decode, sign and valid pipeline, and the stall logic.
// TESTING (OUTPUT_WIDTH=16, LUT_ADDR_WIDTH=10, PHASE_WIDTH=32, BYTE_ALIGNED=1)
// - Reset, then enable = 1, phase_inc = 0, tready = 1 -> tvalid after 4 cycles; every sample re = 32767, im = 25, tdata = 0x0019_7FFF.
// - phase_inc = 0x4000_0000 -> repeating (re, im) = (32767, 25), (-25, 32767), (-32767, -25), (25, -32767).
// - phase_inc = 0x0123_4567, 10000 samples -> every sample matches the bit-exact model; |re|,|im| <= 32767; no sample is skipped or duplicated.
// - tready random at 50% -> tdata stable while stalled; accepted sequence identical to the run with tready = 1.
// - sync_clear with phase_offset = 0x8000_0000 while stalled -> the first sample generated after the stall clears is (-32767, -25).
// - aresetn pulse mid-stream -> tvalid = 0 immediately; after release, sequence restarts at (32767, 25).

Source files
------------

// File: rtl/complex_nco_pkg.sv
// Shared definitions for the complex NCO.
//   eff_port_width : packed {im, re} port width, optionally padded to whole 16-bit lanes
//   quad_e         : phase quadrant taken from the top two accumulator bits
//   quarter_sine   : elaboration-time quarter-wave table entry
//                    T[k] = round(amp * sin(pi/2 * (k + 0.5) / 2^addr_w))
package complex_nco_pkg;

    typedef enum logic [1:0] {
        QUAD0 = 2'd0,
        QUAD1 = 2'd1,
        QUAD2 = 2'd2,
        QUAD3 = 2'd3
    } quad_e;

    localparam real HALF_PI      = 1.5707963267948966;
    localparam int  TAYLOR_TERMS = 16;

    function automatic int eff_port_width(input int output_width, input bit byte_aligned);
        return byte_aligned ? ((2 * output_width + 15) / 16) * 16 : 2 * output_width;
    endfunction

    // Odd Taylor series; the argument never exceeds pi/2, so sixteen terms
    // are accurate far beyond the last table bit.
    function automatic int quarter_sine(input int k, input int addr_w, input int amp);
        real x;
        real term;
        real sum;
        x    = HALF_PI * (real'(k) + 0.5) / real'(1 << addr_w);
        term = x;
        sum  = x;
        for (int n = 1; n < TAYLOR_TERMS; n++) begin
            term = -term * x * x / real'((2 * n) * (2 * n + 1));
            sum  = sum + term;
        end
        return $rtoi(real'(amp) * sum + 0.5);
    endfunction

endpackage

// File: rtl/complex_nco_lut.sv
// Dual-read quarter-wave sine ROM with a registered read.
//   clk_i              : clock
//   ce_i               : read enable; outputs hold while low
//   addr_a_i, addr_b_i : table indices (the top level drives a and ~a)
//   data_a_o, data_b_o : unsigned magnitudes 0 .. 2^(OUTPUT_WIDTH-1)-1, one cycle after the address
module complex_nco_lut
    import complex_nco_pkg::*;
#(
    parameter int OUTPUT_WIDTH   = 16,
    parameter int LUT_ADDR_WIDTH = 10
) (
    input  logic                      clk_i,
    input  logic                      ce_i,
    input  logic [LUT_ADDR_WIDTH-1:0] addr_a_i,
    input  logic [LUT_ADDR_WIDTH-1:0] addr_b_i,
    output logic [OUTPUT_WIDTH-2:0]   data_a_o,
    output logic [OUTPUT_WIDTH-2:0]   data_b_o
);

    localparam int DEPTH = 1 << LUT_ADDR_WIDTH;
    localparam int TAB_W = OUTPUT_WIDTH - 1;
    localparam int AMP   = (1 << TAB_W) - 1;

    logic [TAB_W-1:0] rom [DEPTH];
    logic [TAB_W-1:0] data_a_q;
    logic [TAB_W-1:0] data_b_q;

    // Every entry is a constant evaluated at elaboration, so this folds into a ROM.
    for (genvar k = 0; k < DEPTH; k++) begin : g_rom
        localparam int VAL = quarter_sine(k, LUT_ADDR_WIDTH, AMP);
        assign rom[k] = TAB_W'(VAL);
    end

    always_ff @(posedge clk_i) begin
        if (ce_i) begin
            data_a_q <= rom[addr_a_i];
            data_b_q <= rom[addr_b_i];
        end
    end

    assign data_a_o = data_a_q;
    assign data_b_o = data_b_q;

endmodule

// File: rtl/complex_nco.sv
// Numerically controlled oscillator streaming e^(j*phi[n]) as {im, re} on an AXI-Stream master.
//   aclk, aresetn       : clock, asynchronous active-low reset
//   enable              : 1 = a new sample enters the pipeline on each advancing cycle
//   sync_clear          : load the accumulator with phase_offset (held if stalled)
//   phase_inc           : frequency word, modulo 2^PHASE_WIDTH
//   phase_offset        : value loaded by sync_clear
//   m_axis_dout_tdata   : re in the low half, im in the high half, each sign-padded
//   m_axis_dout_tvalid  : sample valid
//   m_axis_dout_tready  : downstream ready
module complex_nco
    import complex_nco_pkg::*;
#(
    parameter int  OUTPUT_WIDTH   = 16,
    parameter int  PHASE_WIDTH    = 32,
    parameter int  LUT_ADDR_WIDTH = 10,
    parameter bit  BYTE_ALIGNED   = 1'b1,
    localparam int EFF_PORT_WIDTH = eff_port_width(OUTPUT_WIDTH, BYTE_ALIGNED)
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic                      enable,
    input  logic                      sync_clear,
    input  logic [PHASE_WIDTH-1:0]    phase_inc,
    input  logic [PHASE_WIDTH-1:0]    phase_offset,
    output logic [EFF_PORT_WIDTH-1:0] m_axis_dout_tdata,
    output logic                      m_axis_dout_tvalid,
    input  logic                      m_axis_dout_tready
);

    localparam int HALF_W = EFF_PORT_WIDTH / 2;
    localparam int TAB_W  = OUTPUT_WIDTH - 1;
    localparam int PH_W   = LUT_ADDR_WIDTH + 2;

    logic                       advance;
    logic                       clear_now;
    logic                       clr_pend_q, clr_pend_d;
    logic [PHASE_WIDTH-1:0]     acc_q, acc_d;

    logic [PH_W-1:0]            phase_p1_q;
    logic                       vld_p1_q;
    quad_e                      quad_p2_q;
    logic [LUT_ADDR_WIDTH-1:0]  addr_p2_q;
    logic [LUT_ADDR_WIDTH-1:0]  addr_n_p2_q;
    logic                       vld_p2_q;
    quad_e                      quad_p3_q;
    logic [TAB_W-1:0]           tab_a_p3;
    logic [TAB_W-1:0]           tab_n_p3;
    logic                       vld_p3_q;
    logic [EFF_PORT_WIDTH-1:0]  tdata_q, tdata_d;
    logic                       vld_p4_q;

    logic signed [OUTPUT_WIDTH-1:0] tab_a_s, tab_n_s;
    logic signed [OUTPUT_WIDTH-1:0] cos_d, sin_d;

    // The whole pipeline, accumulator included, stalls only while a valid
    // output is being refused, so samples are never dropped or repeated.
    assign advance   = !(vld_p4_q && !m_axis_dout_tready);
    assign clear_now = sync_clear || clr_pend_q;
    assign clr_pend_d = clear_now && !advance;

    always_comb begin
        acc_d = acc_q;
        if (clear_now) begin
            acc_d = phase_offset;
        end else if (enable) begin
            acc_d = acc_q + phase_inc;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            acc_q      <= '0;
            clr_pend_q <= 1'b0;
            vld_p1_q   <= 1'b0;
            vld_p2_q   <= 1'b0;
            vld_p3_q   <= 1'b0;
            vld_p4_q   <= 1'b0;
            tdata_q    <= '0;
        end else begin
            clr_pend_q <= clr_pend_d;
            if (advance) begin
                acc_q    <= acc_d;
                vld_p1_q <= enable;
                vld_p2_q <= vld_p1_q;
                vld_p3_q <= vld_p2_q;
                vld_p4_q <= vld_p3_q;
                tdata_q  <= tdata_d;
            end
        end
    end

    // S1: capture the pre-add phase; only the bits feeding the table matter.
    // S2: split into quadrant and table index, and precompute the mirrored index.
    always_ff @(posedge aclk) begin
        if (advance) begin
            phase_p1_q  <= acc_q[PHASE_WIDTH-1 -: PH_W];
            quad_p2_q   <= quad_e'(phase_p1_q[PH_W-1 -: 2]);
            addr_p2_q   <= phase_p1_q[LUT_ADDR_WIDTH-1:0];
            addr_n_p2_q <= ~phase_p1_q[LUT_ADDR_WIDTH-1:0];
            quad_p3_q   <= quad_p2_q;
        end
    end

    // S3: registered table reads of T[a] and T[~a].
    complex_nco_lut #(
        .OUTPUT_WIDTH   (OUTPUT_WIDTH),
        .LUT_ADDR_WIDTH (LUT_ADDR_WIDTH)
    ) u_lut (
        .clk_i    (aclk),
        .ce_i     (advance),
        .addr_a_i (addr_p2_q),
        .addr_b_i (addr_n_p2_q),
        .data_a_o (tab_a_p3),
        .data_b_o (tab_n_p3)
    );

    // S4: quadrant sign and select. Table magnitudes never exceed the
    // positive full scale, so negation cannot overflow.
    always_comb begin
        tab_a_s = $signed({1'b0, tab_a_p3});
        tab_n_s = $signed({1'b0, tab_n_p3});
        cos_d   = tab_n_s;
        sin_d   = tab_a_s;
        case (quad_p3_q)
            QUAD0: begin cos_d = tab_n_s;  sin_d = tab_a_s;  end
            QUAD1: begin cos_d = -tab_a_s; sin_d = tab_n_s;  end
            QUAD2: begin cos_d = -tab_n_s; sin_d = -tab_a_s; end
            QUAD3: begin cos_d = tab_a_s;  sin_d = -tab_n_s; end
        endcase
        // Signed size casts replicate each component's sign into its padding.
        tdata_d = {HALF_W'(sin_d), HALF_W'(cos_d)};
    end

    assign m_axis_dout_tdata  = tdata_q;
    assign m_axis_dout_tvalid = vld_p4_q;

endmodule
